// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode slice: opcodes, decoded bundle and stage states.
// XLEN is fixed here because decoded_t carries an XLEN-wide immediate.
package decode_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [1:0] {
    FU_ALU    = 2'b00,
    FU_BRANCH = 2'b01,
    FU_LSU    = 2'b10,
    FU_MULDIV = 2'b11
  } fu_type_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_OP     = 2'b10,
    ALU_OPIMM  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } stage_state_e;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] imm;
    alu_op_e         alu_op;
    fu_type_e        fu_type;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            illegal;
  } decoded_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I instruction -> decoded_t decode.
// Define DECODE_MEXT_EN to accept the M-extension OP encodings (funct7 = 0000001).
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [6:0]  opcode_s;
  logic [6:0]  funct7_s;
  logic [31:0] imm32_s;
  logic        illegal_s;

  assign opcode_s = instr[6:0];
  assign funct7_s = instr[31:25];

  // Field extraction, per-opcode control and illegal-encoding squash.
  always_comb begin
    dec          = '0;
    imm32_s      = 32'h0000_0000;
    illegal_s    = (instr[1:0] != 2'b11);
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.rd       = instr[11:7];
    dec.funct3   = instr[14:12];
    dec.funct7b5 = instr[30];
    case (opcode_s)
      OPC_LUI, OPC_AUIPC: begin
        imm32_s       = {instr[31:12], 12'h000};
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        imm32_s       = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        dec.fu_type   = FU_BRANCH;
        dec.branch    = 1'b1;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        imm32_s       = {{20{instr[31]}}, instr[31:20]};
        dec.fu_type   = FU_BRANCH;
        dec.alu_src   = 1'b1;
        dec.branch    = 1'b1;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        imm32_s     = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        dec.alu_op  = ALU_BRANCH;
        dec.fu_type = FU_BRANCH;
        dec.branch  = 1'b1;
      end
      OPC_LOAD: begin
        imm32_s       = {{20{instr[31]}}, instr[31:20]};
        dec.fu_type   = FU_LSU;
        dec.alu_src   = 1'b1;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        imm32_s       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        dec.fu_type   = FU_LSU;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OPC_OP_IMM: begin
        imm32_s       = {{20{instr[31]}}, instr[31:20]};
        dec.alu_op    = ALU_OPIMM;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_OP: begin
        dec.alu_op    = ALU_OP;
        dec.reg_write = 1'b1;
        if ((funct7_s == F7_BASE) || (funct7_s == F7_ALT)) begin
          dec.fu_type = FU_ALU;
`ifdef DECODE_MEXT_EN
        end else if (funct7_s == F7_MULDIV) begin
          dec.fu_type = FU_MULDIV;
`endif
        end else begin
          illegal_s = 1'b1;
        end
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
    dec.imm = XLEN'($signed(imm32_s));
    // Illegal instructions still flow downstream but must have no side effects.
    dec.illegal   = illegal_s;
    dec.reg_write = dec.reg_write && (dec.rd != 5'd0) && !illegal_s;
    dec.mem_read  = dec.mem_read  && !illegal_s;
    dec.mem_write = dec.mem_write && !illegal_s;
    dec.branch    = dec.branch    && !illegal_s;
    dec.jump      = dec.jump      && !illegal_s;
    dec.fu_type   = illegal_s ? FU_ALU : dec.fu_type;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: output register plus 1-entry skid, valid/ready both sides.
// Optional M-extension decode via DECODE_MEXT_EN (see decode_comb); XLEN is set in decode_pkg.
module decode_stage
  import decode_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [31:0]     i_instr,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_valid,
  output logic            o_ready,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [PC_W-1:0] o_pc,
  output decoded_t        o_dec
);

  stage_state_e    state_r;
  stage_state_e    state_next_s;
  logic            valid_r;
  logic            ready_r;
  decoded_t        out_dec_r;
  decoded_t        skid_dec_r;
  logic [PC_W-1:0] out_pc_r;
  logic [PC_W-1:0] skid_pc_r;
  decoded_t        dec_s;
  logic            accept_s;
  logic            load_out_s;
  logic            load_skid_s;
  logic            out_from_skid_s;

  decode_comb u_decode_comb (
    .instr (i_instr),
    .dec   (dec_s)
  );

  assign accept_s = i_valid && ready_r;
  assign o_ready  = ready_r;
  assign o_valid  = valid_r;
  assign o_pc     = out_pc_r;
  assign o_dec    = out_dec_r;

  // State register; valid/ready are registered copies of the next occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_EMPTY;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      valid_r <= (state_next_s != ST_EMPTY);
      ready_r <= (state_next_s != ST_TWO);
    end
  end

  // Next-state: flush wins over every transfer.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: state_next_s = accept_s ? ST_ONE : ST_EMPTY;
        ST_ONE: begin
          if (accept_s && !i_ready) begin
            state_next_s = ST_TWO;
          end else if (accept_s || !i_ready) begin
            state_next_s = ST_ONE;
          end else begin
            state_next_s = ST_EMPTY;
          end
        end
        ST_TWO:   state_next_s = i_ready ? ST_ONE : ST_TWO;
        default:  state_next_s = ST_EMPTY;
      endcase
    end
  end

  // Datapath load enables derived from the current state.
  always_comb begin
    load_out_s      = 1'b0;
    load_skid_s     = 1'b0;
    out_from_skid_s = 1'b0;
    if (flush) begin
      load_out_s = 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: load_out_s = accept_s;
        ST_ONE: begin
          load_out_s  = accept_s && i_ready;
          load_skid_s = accept_s && !i_ready;
        end
        ST_TWO: begin
          load_out_s      = i_ready;
          out_from_skid_s = 1'b1;
        end
        default: load_out_s = 1'b0;
      endcase
    end
  end

  // Output and skid payload registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_dec_r  <= '0;
      out_pc_r   <= '0;
      skid_dec_r <= '0;
      skid_pc_r  <= '0;
    end else begin
      if (load_out_s) begin
        out_dec_r <= out_from_skid_s ? skid_dec_r : dec_s;
        out_pc_r  <= out_from_skid_s ? skid_pc_r  : i_pc;
      end
      if (load_skid_s) begin
        skid_dec_r <= dec_s;
        skid_pc_r  <= i_pc;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (ordering, flush, reset, decode fields).
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] i_instr;
  logic [8:0]  i_pc;
  logic        i_valid;
  logic        o_ready;
  logic        o_valid;
  logic        i_ready;
  logic [8:0]  o_pc;
  decoded_t    o_dec;
  int          n_pass = 0;
  int          n_total = 0;

  decode_stage #(.PC_W(9)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .i_instr (i_instr),
    .i_pc    (i_pc),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_pc    (o_pc),
    .o_dec   (o_dec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [8:0] pc);
    i_instr = instr;
    i_pc    = pc;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; i_instr = 32'h0; i_pc = 9'h0; i_valid = 1'b0; i_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_total++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %0h expected 0", o_valid); else n_pass++;
    n_total++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %0h expected 1", o_ready); else n_pass++;
    n_total++; if (o_pc !== 9'h000) $display("FAIL reset_pc: got %0h expected 0", o_pc); else n_pass++;
    n_total++; if (o_dec !== '0) $display("FAIL reset_dec: got %0h expected 0", o_dec); else n_pass++;
  endtask

  task automatic test_addi();
    i_ready = 1'b1;
    issue(32'hFFF0_8293, 9'h004);
    n_total++; if (o_valid !== 1'b1) $display("FAIL addi_valid: got %0h expected 1", o_valid); else n_pass++;
    n_total++; if (o_pc !== 9'h004) $display("FAIL addi_pc: got %0h expected 4", o_pc); else n_pass++;
    n_total++; if (o_dec.rd !== 5'd5) $display("FAIL addi_rd: got %0d expected 5", o_dec.rd); else n_pass++;
    n_total++; if (o_dec.rs1 !== 5'd1) $display("FAIL addi_rs1: got %0d expected 1", o_dec.rs1); else n_pass++;
    n_total++; if (o_dec.imm !== 32'hFFFF_FFFF) $display("FAIL addi_imm: got %0h expected ffffffff", o_dec.imm); else n_pass++;
    n_total++; if (o_dec.alu_op !== 2'b11) $display("FAIL addi_alu_op: got %0b expected 11", o_dec.alu_op); else n_pass++;
    n_total++; if (o_dec.alu_src !== 1'b1) $display("FAIL addi_alu_src: got %0b expected 1", o_dec.alu_src); else n_pass++;
    n_total++; if (o_dec.reg_write !== 1'b1) $display("FAIL addi_reg_write: got %0b expected 1", o_dec.reg_write); else n_pass++;
    tick();
    n_total++; if (o_valid !== 1'b0) $display("FAIL addi_drain: got %0h expected 0", o_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [8:0] got[$];
    logic [8:0] exp_pc[3];
    logic       fire_in;
    exp_pc[0] = 9'h010; exp_pc[1] = 9'h014; exp_pc[2] = 9'h018;
    i_ready = 1'b0;
    issue(32'h0010_0093, 9'h010);
    issue(32'h0020_0113, 9'h014);
    n_total++; if (o_ready !== 1'b0) $display("FAIL b2b_two_ready: got %0h expected 0", o_ready); else n_pass++;
    n_total++; if (o_pc !== 9'h010) $display("FAIL b2b_two_pc: got %0h expected 10", o_pc); else n_pass++;
    i_instr = 32'h0030_0193; i_pc = 9'h018; i_valid = 1'b1;
    tick();
    n_total++; if (o_ready !== 1'b0) $display("FAIL b2b_hold_ready: got %0h expected 0", o_ready); else n_pass++;
    n_total++; if (o_pc !== 9'h010) $display("FAIL b2b_hold_pc: got %0h expected 10", o_pc); else n_pass++;
    i_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (o_valid && i_ready) got.push_back(o_pc);
      fire_in = i_valid && o_ready;
      tick();
      if (fire_in) i_valid = 1'b0;
    end
    n_total++; if (got.size() != 3) $display("FAIL b2b_count: got %0d expected 3", got.size()); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (k >= got.size()) $display("FAIL b2b_order[%0d]: got none expected %0h", k, exp_pc[k]);
      else if (got[k] !== exp_pc[k]) $display("FAIL b2b_order[%0d]: got %0h expected %0h", k, got[k], exp_pc[k]);
      else n_pass++;
    end
    n_total++; if (o_valid !== 1'b0) $display("FAIL b2b_empty: got %0h expected 0", o_valid); else n_pass++;
  endtask

  task automatic test_jal();
    i_ready = 1'b1;
    issue(32'h0010_00EF, 9'h020);
    n_total++; if (o_dec.imm !== 32'h0000_0800) $display("FAIL jal_imm: got %0h expected 800", o_dec.imm); else n_pass++;
    n_total++; if (o_dec.fu_type !== 2'b01) $display("FAIL jal_fu: got %0b expected 01", o_dec.fu_type); else n_pass++;
    n_total++; if (o_dec.branch !== 1'b1) $display("FAIL jal_branch: got %0b expected 1", o_dec.branch); else n_pass++;
    n_total++; if (o_dec.jump !== 1'b1) $display("FAIL jal_jump: got %0b expected 1", o_dec.jump); else n_pass++;
    n_total++; if (o_dec.reg_write !== 1'b1) $display("FAIL jal_reg_write: got %0b expected 1", o_dec.reg_write); else n_pass++;
    n_total++; if (o_dec.rd !== 5'd1) $display("FAIL jal_rd: got %0d expected 1", o_dec.rd); else n_pass++;
  endtask

  task automatic test_store_branch();
    i_ready = 1'b1;
    issue(32'h0020_A423, 9'h024);
    n_total++; if (o_dec.imm !== 32'h0000_0008) $display("FAIL sw_imm: got %0h expected 8", o_dec.imm); else n_pass++;
    n_total++; if (o_dec.mem_write !== 1'b1) $display("FAIL sw_mem_write: got %0b expected 1", o_dec.mem_write); else n_pass++;
    n_total++; if (o_dec.fu_type !== 2'b10) $display("FAIL sw_fu: got %0b expected 10", o_dec.fu_type); else n_pass++;
    n_total++; if (o_dec.reg_write !== 1'b0) $display("FAIL sw_reg_write: got %0b expected 0", o_dec.reg_write); else n_pass++;
    issue(32'hFE20_8EE3, 9'h028);
    n_total++; if (o_dec.imm !== 32'hFFFF_FFFC) $display("FAIL beq_imm: got %0h expected fffffffc", o_dec.imm); else n_pass++;
    n_total++; if (o_dec.alu_op !== 2'b01) $display("FAIL beq_alu_op: got %0b expected 01", o_dec.alu_op); else n_pass++;
    n_total++; if ({o_dec.branch, o_dec.jump} !== 2'b10) $display("FAIL beq_br_jump: got %0b expected 10", {o_dec.branch, o_dec.jump}); else n_pass++;
    n_total++; if (o_pc !== 9'h028) $display("FAIL beq_pc: got %0h expected 28", o_pc); else n_pass++;
  endtask

  task automatic test_illegal();
    i_ready = 1'b1;
    issue(32'h0000_0000, 9'h030);
    n_total++; if (o_dec.illegal !== 1'b1) $display("FAIL zero_illegal: got %0b expected 1", o_dec.illegal); else n_pass++;
    n_total++; if (o_dec.reg_write !== 1'b0) $display("FAIL zero_reg_write: got %0b expected 0", o_dec.reg_write); else n_pass++;
    issue(32'h0000_0013, 9'h034);
    n_total++; if (o_dec.illegal !== 1'b0) $display("FAIL nop_illegal: got %0b expected 0", o_dec.illegal); else n_pass++;
    n_total++; if (o_dec.reg_write !== 1'b0) $display("FAIL nop_reg_write: got %0b expected 0", o_dec.reg_write); else n_pass++;
    issue(32'h4020_81B3, 9'h038);
    n_total++; if ({o_dec.illegal, o_dec.reg_write} !== 2'b01) $display("FAIL sub_flags: got %0b expected 01", {o_dec.illegal, o_dec.reg_write}); else n_pass++;
    issue(32'h0820_81B3, 9'h03C);
    n_total++; if ({o_dec.illegal, o_dec.reg_write} !== 2'b10) $display("FAIL badf7_flags: got %0b expected 10", {o_dec.illegal, o_dec.reg_write}); else n_pass++;
  endtask

  task automatic test_mul();
    i_ready = 1'b1;
    issue(32'h0220_81B3, 9'h040);
`ifdef DECODE_MEXT_EN
    n_total++; if (o_dec.fu_type !== 2'b11) $display("FAIL mul_fu: got %0b expected 11", o_dec.fu_type); else n_pass++;
    n_total++; if (o_dec.reg_write !== 1'b1) $display("FAIL mul_reg_write: got %0b expected 1", o_dec.reg_write); else n_pass++;
    n_total++; if (o_dec.illegal !== 1'b0) $display("FAIL mul_illegal: got %0b expected 0", o_dec.illegal); else n_pass++;
`else
    n_total++; if (o_dec.fu_type !== 2'b00) $display("FAIL mul_fu: got %0b expected 00", o_dec.fu_type); else n_pass++;
    n_total++; if (o_dec.reg_write !== 1'b0) $display("FAIL mul_reg_write: got %0b expected 0", o_dec.reg_write); else n_pass++;
    n_total++; if (o_dec.illegal !== 1'b1) $display("FAIL mul_illegal: got %0b expected 1", o_dec.illegal); else n_pass++;
`endif
    tick();
  endtask

  task automatic test_flush();
    logic saw_valid;
    i_ready = 1'b0;
    issue(32'h0010_0093, 9'h050);
    issue(32'h0020_0113, 9'h054);
    i_instr = 32'h0030_0193; i_pc = 9'h058; i_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; i_valid = 1'b0;
    n_total++; if (o_valid !== 1'b0) $display("FAIL flush_valid: got %0h expected 0", o_valid); else n_pass++;
    n_total++; if (o_ready !== 1'b1) $display("FAIL flush_ready: got %0h expected 1", o_ready); else n_pass++;
    i_ready = 1'b1;
    saw_valid = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      if (o_valid !== 1'b0) saw_valid = 1'b1;
    end
    n_total++; if (saw_valid !== 1'b0) $display("FAIL flush_ghost: got %0b expected 0", saw_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    issue(32'h0010_0093, 9'h060);
    issue(32'h0020_0113, 9'h064);
    n_total++; if (o_ready !== 1'b0) $display("FAIL rstmid_pre_ready: got %0h expected 0", o_ready); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++; if (o_valid !== 1'b0) $display("FAIL rstmid_valid: got %0h expected 0", o_valid); else n_pass++;
    n_total++; if (o_pc !== 9'h000) $display("FAIL rstmid_pc: got %0h expected 0", o_pc); else n_pass++;
    tick();
    reset = 1'b0;
    i_ready = 1'b1;
    tick();
    n_total++; if ({o_valid, o_ready} !== 2'b01) $display("FAIL rstmid_after: got %0b expected 01", {o_valid, o_ready}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_jal();
    test_store_branch();
    test_illegal();
    test_mul();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
